// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between instruction fetch and data side.
// Data side has priority, with a starvation guard for fetch and a per-grant watchdog.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_req,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              timeout_err,
  output logic              err_src
);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  localparam int DCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int WCNT_W = $clog2(TIMEOUT);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(STARVE_LIMIT);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              src_q, src_d;

  logic dreq;
  logic i_act;
  logic d_act;

  // A grant only drives the RAM while its requester is still asking.
  always_comb begin
    dreq      = dREN | dWEN;
    i_act     = (state_q == IGRANT) & iREN;
    d_act     = (state_q == DGRANT) & dreq;
    ram_req   = i_act | d_act;
    ram_wen   = d_act & dWEN;
    ram_addr  = i_act ? iaddr : (d_act ? daddr : '0);
    ram_wdata = d_act ? dstore : '0;
    ihit      = i_act & ram_ready;
    dhit      = d_act & ram_ready;
    iload     = ram_rdata;
    dload     = ram_rdata;
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    src_d   = src_q;
    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (dreq && !(iREN && dcnt_q == DCNT_MAX)) begin
          state_d = DGRANT;
          if (iREN && dcnt_q != DCNT_MAX) dcnt_d = dcnt_q + 1'b1;
        end else if (iREN) begin
          state_d = IGRANT;
          dcnt_d  = '0;
        end
      end
      IGRANT, DGRANT: begin
        if (!ram_req || ram_ready) begin
          state_d = IDLE;
        end else if (wcnt_q == WCNT_MAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
          if (!err_q) src_d = (state_q == DGRANT);
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Fetch not waiting means there is nothing to be starved.
    if (!iREN) dcnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      src_q   <= src_d;
    end
  end

  assign timeout_err = err_q;
  assign err_src     = src_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dhit;
  logic [31:0] dload;
  logic        ram_req;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;
  logic        timeout_err;
  logic        err_src;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .timeout_err(timeout_err), .err_src(err_src)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), how long the
  // current owner has waited, and how many data grants fetch has sat through.
  int owner  = 0;
  int age    = 0;
  int streak = 0;
  bit m_err  = 1'b0;
  bit m_src  = 1'b0;
  bit exp_ihit, exp_dhit;
  bit hit_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic modelReset();
    owner = 0; age = 0; streak = 0; m_err = 1'b0; m_src = 1'b0;
  endtask

  task automatic applyStimulus(input bit ir, input bit dr, input bit dw, input bit rdy);
    iREN = ir; dREN = dr; dWEN = dw; ram_ready = rdy;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 after the rising edge.
  task automatic step();
    bit dreq, act;
    logic [31:0] e_addr, e_wdata;
    @(negedge CLK);
    ram_rdata = $urandom;
    #1;
    dreq    = dREN | dWEN;
    act     = (owner == 1) ? iREN : ((owner == 2) ? dreq : 1'b0);
    e_addr  = !act ? 32'h0 : ((owner == 1) ? iaddr : daddr);
    e_wdata = (act && owner == 2) ? dstore : 32'h0;
    exp_ihit = (owner == 1) && act && ram_ready;
    exp_dhit = (owner == 2) && act && ram_ready;
    checkOutput("ram_req", 32'(ram_req), 32'(act));
    checkOutput("ram_wen", 32'(ram_wen), 32'(act && owner == 2 && dWEN));
    checkOutput("ram_addr", ram_addr, e_addr);
    checkOutput("ram_wdata", ram_wdata, e_wdata);
    checkOutput("ihit", 32'(ihit), 32'(exp_ihit));
    checkOutput("dhit", 32'(dhit), 32'(exp_dhit));
    checkOutput("timeout_err", 32'(timeout_err), 32'(m_err));
    checkOutput("err_src", 32'(err_src), 32'(m_src));
    if (exp_ihit) checkOutput("iload", iload, ram_rdata);
    if (exp_dhit && !dWEN) checkOutput("dload", dload, ram_rdata);
    if (ihit) hit_log.push_back(1'b0);
    if (dhit) hit_log.push_back(1'b1);

    if (owner == 0) begin
      if (dreq && !(iREN && streak == LIMIT)) begin
        owner = 2; age = 0;
        if (iREN && streak < LIMIT) streak++;
      end else if (iREN) begin
        owner = 1; age = 0; streak = 0;
      end
    end else if (!act || ram_ready) begin
      owner = 0;
    end else if (age == TMO - 1) begin
      if (!m_err) m_src = (owner == 2);
      m_err = 1'b1;
      owner = 0;
    end else begin
      age++;
    end
    if (!iREN) streak = 0;
    @(posedge CLK);
    #1;
  endtask

  // Requesters hold until their predicted hit, then release unless told to keep asking.
  task automatic runCycles(input int n, input bit keep);
    for (int k = 0; k < n; k++) begin
      step();
      if (!keep) begin
        if (exp_ihit) iREN = 1'b0;
        if (exp_dhit) begin dREN = 1'b0; dWEN = 1'b0; end
      end
    end
  endtask

  initial begin
    bit exp_pat [10];
    bit rnd_ir, rnd_dr, rnd_dw;

    $display("[TB] reset and first fetch");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    iaddr = 32'h40;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checkOutput("rst_ram_req", 32'(ram_req), 32'h0);
    checkOutput("rst_ihit", 32'(ihit), 32'h0);
    checkOutput("rst_ram_addr", ram_addr, 32'h0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);
    checkOutput("rst_err_src", 32'(err_src), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    modelReset();
    hit_log.delete();
    runCycles(4, 1'b0);
    checkOutput("t1_hits", 32'(hit_log.size()), 32'd1);

    $display("[TB] simultaneous fetch and write");
    hit_log.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    daddr = 32'h100; dstore = 32'hBEEF; iaddr = 32'h44;
    runCycles(6, 1'b0);
    checkOutput("t2_hits", 32'(hit_log.size()), 32'd2);
    if (hit_log.size() == 2) begin
      checkOutput("t2_first_is_D", 32'(hit_log[0]), 32'd1);
      checkOutput("t2_second_is_I", 32'(hit_log[1]), 32'd0);
    end

    $display("[TB] starvation guard");
    hit_log.delete();
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    daddr = 32'h200; iaddr = 32'h48;
    runCycles(20, 1'b1);
    checkOutput("t3_hits", 32'(hit_log.size()), 32'd10);
    for (int k = 0; k < 10 && k < hit_log.size(); k++)
      checkOutput($sformatf("t3_order_%0d", k), 32'(hit_log[k]), 32'(exp_pat[k]));
    checkOutput("t3_dcnt_after_I", 32'(dut.dcnt_q), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    runCycles(2, 1'b0);

    $display("[TB] data grant watchdog");
    hit_log.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    daddr = 32'h300;
    runCycles(1 + TMO, 1'b0);
    checkOutput("t4_timeout_err", 32'(timeout_err), 32'h1);
    checkOutput("t4_err_src", 32'(err_src), 32'h1);
    checkOutput("t4_no_dhit", 32'(hit_log.size()), 32'h0);
    dREN = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    iaddr = 32'h4C;
    runCycles(4, 1'b0);
    checkOutput("t4_err_sticky", 32'(timeout_err), 32'h1);
    checkOutput("t4_src_sticky", 32'(err_src), 32'h1);

    $display("[TB] fetch abandoned mid-grant");
    hit_log.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    iaddr = 32'h50;
    runCycles(4, 1'b0);
    iREN = 1'b0;
    ram_ready = 1'b1;
    runCycles(3, 1'b0);
    checkOutput("t5_no_ihit", 32'(hit_log.size()), 32'h0);

    $display("[TB] reset during data grant");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    daddr = 32'h400; dstore = 32'h1234;
    runCycles(3, 1'b0);
    checkOutput("t6_granted", 32'(ram_req), 32'h1);
    RST = 1'b1;
    #1;
    checkOutput("t6_async_req", 32'(ram_req), 32'h0);
    checkOutput("t6_async_wen", 32'(ram_wen), 32'h0);
    checkOutput("t6_err_cleared", 32'(timeout_err), 32'h0);
    modelReset();
    dWEN = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    checkOutput("t6_dcnt", 32'(dut.dcnt_q), 32'h0);
    checkOutput("t6_wcnt", 32'(dut.wcnt_q), 32'h0);
    checkOutput("t6_src", 32'(err_src), 32'h0);
    runCycles(2, 1'b0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      if (!iREN && $urandom_range(0, 99) < 40) begin
        iREN = 1'b1; iaddr = $urandom;
      end else if (iREN && $urandom_range(0, 99) < 3) begin
        iREN = 1'b0;
      end
      if (!(dREN | dWEN) && $urandom_range(0, 99) < 45) begin
        rnd_dr = 1'($urandom); rnd_dw = 1'($urandom);
        if (!rnd_dr && !rnd_dw) rnd_dr = 1'b1;
        dREN = rnd_dr; dWEN = rnd_dw; daddr = $urandom; dstore = $urandom;
      end else if ((dREN | dWEN) && $urandom_range(0, 99) < 3) begin
        dREN = 1'b0; dWEN = 1'b0;
      end
      ram_ready = ($urandom_range(0, 99) < 60);
      rnd_ir = 1'b0;
      step();
      if (exp_ihit) iREN = rnd_ir;
      if (exp_dhit) begin dREN = 1'b0; dWEN = 1'b0; end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
